// File: rtl/spiram_bus_adapter.sv
// CPU-side front end for the SPI RAM word controller: turns rstrb/wmask strobes into
// full-word rd/wr handshakes, with read-modify-write for partial writes and a one-word cache.
module spiram_bus_adapter #(
    parameter int ACK_TIMEOUT = 64,
    parameter bit CACHE_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_word_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wmask,
    input  logic        cpu_rstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rbusy,
    output logic        cpu_wbusy,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic [15:0] ram_word_address,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rbusy,
    input  logic        ram_wbusy,
    output logic        err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    // IDLE waits for a strobe; *_REQ hold a strobe until busy rises; *_WAIT wait for busy to fall
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RMW_RD_REQ, RMW_RD_WAIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] tmo_cnt, tmo_cnt_n;
    logic [31:0]   cpu_rdata_n, ram_wdata_n, lat_wdata, lat_wdata_n;
    logic [31:0]   cache_data, cache_data_n;
    logic [15:0]   ram_word_address_n, cache_tag, cache_tag_n;
    logic [3:0]    lat_wmask, lat_wmask_n;
    logic          cpu_rbusy_n, cpu_wbusy_n, ram_rd_n, ram_wr_n, err_n;
    logic          cache_valid, cache_valid_n;
    logic          hit, tmo_hit, abort;
    logic [31:0]   cpu_merge, rmw_merge;

    function automatic logic [31:0] merge(input logic [31:0] nw, input logic [3:0] m,
                                          input logic [31:0] old);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = m[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign hit       = CACHE_EN && cache_valid && (cache_tag == cpu_word_addr);
    assign tmo_hit   = (tmo_cnt == CW'(ACK_TIMEOUT - 1));
    assign cpu_merge = merge(cpu_wdata, cpu_wmask, cache_data);
    assign rmw_merge = merge(lat_wdata, lat_wmask, ram_rdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            cpu_rdata        <= '0;
            cpu_rbusy        <= 1'b0;
            cpu_wbusy        <= 1'b0;
            ram_rd           <= 1'b0;
            ram_wr           <= 1'b0;
            ram_word_address <= '0;
            ram_wdata        <= '0;
            err              <= 1'b0;
            lat_wdata        <= '0;
            lat_wmask        <= '0;
            cache_valid      <= 1'b0;
            cache_tag        <= '0;
            cache_data       <= '0;
        end else begin
            state            <= state_n;
            tmo_cnt          <= tmo_cnt_n;
            cpu_rdata        <= cpu_rdata_n;
            cpu_rbusy        <= cpu_rbusy_n;
            cpu_wbusy        <= cpu_wbusy_n;
            ram_rd           <= ram_rd_n;
            ram_wr           <= ram_wr_n;
            ram_word_address <= ram_word_address_n;
            ram_wdata        <= ram_wdata_n;
            err              <= err_n;
            lat_wdata        <= lat_wdata_n;
            lat_wmask        <= lat_wmask_n;
            cache_valid      <= cache_valid_n;
            cache_tag        <= cache_tag_n;
            cache_data       <= cache_data_n;
        end
    end

    always_comb begin
        state_n            = state;
        tmo_cnt_n          = '0;
        cpu_rdata_n        = cpu_rdata;
        cpu_rbusy_n        = cpu_rbusy;
        cpu_wbusy_n        = cpu_wbusy;
        ram_rd_n           = ram_rd;
        ram_wr_n           = ram_wr;
        ram_word_address_n = ram_word_address;
        ram_wdata_n        = ram_wdata;
        err_n              = err;
        lat_wdata_n        = lat_wdata;
        lat_wmask_n        = lat_wmask;
        cache_valid_n      = cache_valid;
        cache_tag_n        = cache_tag;
        cache_data_n       = cache_data;
        abort              = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_wmask != 4'b0000) begin
                    ram_word_address_n = cpu_word_addr;
                    cpu_wbusy_n        = 1'b1;
                    if (cpu_wmask == 4'b1111 || hit) begin
                        ram_wdata_n = cpu_merge;
                        ram_wr_n    = 1'b1;
                        state_n     = WR_REQ;
                        // write-through: full writes allocate, partial hits update in place
                        if (CACHE_EN) begin
                            cache_valid_n = 1'b1;
                            cache_tag_n   = cpu_word_addr;
                            cache_data_n  = cpu_merge;
                        end
                    end else begin
                        lat_wdata_n = cpu_wdata;
                        lat_wmask_n = cpu_wmask;
                        ram_rd_n    = 1'b1;
                        state_n     = RMW_RD_REQ;
                    end
                end else if (cpu_rstrb) begin
                    if (hit) begin
                        cpu_rdata_n = cache_data;
                    end else begin
                        ram_word_address_n = cpu_word_addr;
                        cpu_rbusy_n        = 1'b1;
                        ram_rd_n           = 1'b1;
                        state_n            = RD_REQ;
                    end
                end
            end
            RD_REQ, RMW_RD_REQ: begin
                if (ram_rbusy) begin
                    ram_rd_n = 1'b0;
                    state_n  = (state == RD_REQ) ? RD_WAIT : RMW_RD_WAIT;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            RD_WAIT: begin
                if (!ram_rbusy) begin
                    cpu_rdata_n = ram_rdata;
                    cpu_rbusy_n = 1'b0;
                    state_n     = IDLE;
                    if (CACHE_EN) begin
                        cache_valid_n = 1'b1;
                        cache_tag_n   = ram_word_address;
                        cache_data_n  = ram_rdata;
                    end
                end
            end
            RMW_RD_WAIT: begin
                if (!ram_rbusy) begin
                    ram_wdata_n = rmw_merge;
                    ram_wr_n    = 1'b1;
                    state_n     = WR_REQ;
                    if (CACHE_EN) begin
                        cache_valid_n = 1'b1;
                        cache_tag_n   = ram_word_address;
                        cache_data_n  = rmw_merge;
                    end
                end
            end
            WR_REQ: begin
                if (ram_wbusy) begin
                    ram_wr_n = 1'b0;
                    state_n  = WR_WAIT;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            WR_WAIT: begin
                if (!ram_wbusy) begin
                    cpu_wbusy_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // the controller never answered; the cached word can no longer be trusted
        if (abort) begin
            ram_rd_n      = 1'b0;
            ram_wr_n      = 1'b0;
            cpu_rbusy_n   = 1'b0;
            cpu_wbusy_n   = 1'b0;
            err_n         = 1'b1;
            cache_valid_n = 1'b0;
            state_n       = IDLE;
        end
    end

endmodule

// File: doc/spiram_bus_adapter.md
Name: spiram_bus_adapter

Overview:
- CPU-side front end placed directly upstream of the SPI RAM word controller.
- Converts FemtoRV-style strobes (rstrb, byte wmask) into the controller's full-word rd/wr pulses.
- Partial-byte writes become read-modify-write sequences.
- Holds a one-entry word cache so a repeated read of the same word returns without a serial SPI transaction.

Parameters:
- ACK_TIMEOUT, 64, max cycles to wait for ram_rbusy/ram_wbusy to rise after a strobe before aborting.
- CACHE_EN, 1, 1 enables the one-entry cache; 0 makes every read a miss.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_word_addr  in  16  word address of the request.
- cpu_wdata  in  32  write data, byte lanes aligned to cpu_wmask.
- cpu_wmask  in  4  byte write enables; nonzero for one cycle starts a write.
- cpu_rstrb  in  1  one-cycle read request.
- cpu_rdata  out  32  read data.
- cpu_rbusy  out  1  read in progress.
- cpu_wbusy  out  1  write in progress.
- ram_rd  out  1  read strobe to the SPI RAM controller.
- ram_wr  out  1  write strobe to the SPI RAM controller.
- ram_word_address  out  16  address to the controller.
- ram_wdata  out  32  full-word write data to the controller.
- ram_rdata  in  32  controller read data.
- ram_rbusy  in  1  controller read busy.
- ram_wbusy  in  1  controller write busy.
- err  out  1  sticky: a strobe got no busy response within ACK_TIMEOUT.

Behaviour:
- Reset (async, active-low): every output 0; state IDLE; cache valid=0; timeout counter 0. Reset mid-transaction aborts it and drops ram_rd/ram_wr immediately.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RMW_RD_REQ, RMW_RD_WAIT.
- Requests are sampled only in IDLE. Strobes arriving in any other state are ignored.
- If cpu_rstrb and cpu_wmask!=0 arrive together, the write wins and the read is dropped.
- Read hit (CACHE_EN, valid, tag==cpu_word_addr):
  - cpu_rdata = cached word, registered on the cycle after the strobe.
  - cpu_rbusy stays 0; no ram_rd is issued.
- Read miss:
  - Next cycle: cpu_rbusy=1, ram_word_address=addr, ram_rd=1, state RD_REQ.
  - RD_REQ: ram_rd held until ram_rbusy==1 is sampled, then ram_rd=0 and state RD_WAIT.
  - RD_WAIT: on ram_rbusy==0, register cpu_rdata=ram_rdata, load the cache (tag=addr, valid=1), clear cpu_rbusy, return to IDLE. cpu_rdata is valid on the first cycle cpu_rbusy reads 0.
- Write with full mask (4'b1111), or partial mask that hits the cache:
  - Merged word: for each byte lane, cpu_wdata where the mask bit is 1, else the cached byte.
  - Next cycle: cpu_wbusy=1, ram_wdata=merged word, ram_wr=1, state WR_REQ.
  - WR_REQ: ram_wr held until ram_wbusy==1, then WR_WAIT.
  - WR_WAIT: on ram_wbusy==0, clear cpu_wbusy and return to IDLE.
  - Cache (write-through): updated with the merged word if the tag matches; a full-mask write also allocates.
- Write with partial mask that misses the cache:
  - cpu_wbusy=1; latch cpu_wdata and cpu_wmask.
  - RMW_RD_REQ/RMW_RD_WAIT: same handshake as a read.
  - Merge latched bytes into ram_rdata, then WR_REQ/WR_WAIT.
  - Cache ends valid with the merged word. cpu_rbusy stays 0 throughout.
- Timeout:
  - In any *_REQ state, a counter increments every cycle. It reaching ACK_TIMEOUT without the expected busy: drop the strobe, set err=1, clear busy outputs, invalidate the cache, go to IDLE.
  - err clears only on reset.
- Busy deassertion in a *_WAIT state is treated as completion even if it occurs on the first WAIT cycle.
- Address and data outputs hold stable from the strobe until return to IDLE.
- Latency with the controller acknowledging in 1 cycle:
  - Read miss = 2 + controller read time.
  - Partial-miss write = read time + write time + 4.

Test Plan:
- Read addr 0x0010, model returns 0xDEADBEEF after 40 cycles -> one ram_rd; cpu_rbusy high ~41 cycles; cpu_rdata=0xDEADBEEF when busy drops.
- Immediate re-read of 0x0010 -> no ram_rd; cpu_rbusy stays 0; cpu_rdata=0xDEADBEEF next cycle.
- Write mask 4'b0010, wdata 0x0000AB00 to 0x0010 (cached 0xDEADBEEF) -> no ram_rd; ram_wdata=0xDEADABEF; next read hits 0xDEADABEF.
- Write mask 4'b1000, wdata 0x11000000 to uncached 0x0200, RAM holds 0x22334455 -> ram_rd then ram_wr; ram_wdata=0x11334455; cpu_wbusy high throughout.
- cpu_rstrb and cpu_wmask=4'b1111 together -> only ram_wr issued; cpu_rbusy stays 0.
- Model never raises ram_rbusy, ACK_TIMEOUT=64 -> ram_rd drops after 64 cycles; err=1; cpu_rbusy=0; a later reset clears err.
